// File: rtl/flicker_pkg.sv
// Shared types and constants for the candle-flicker datapath.
// Holds the sequencer state encoding, level width and LFSR seed.
package flicker_pkg;

    localparam int LEVEL_W = 4;
    localparam logic [15:0] LFSR_SEED = 16'hBEEF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SAMPLE,
        RAMP
    } state_t;

    function automatic logic [LEVEL_W-1:0] step_toward(
        input logic [LEVEL_W-1:0] cur,
        input logic [LEVEL_W-1:0] tgt
    );
        return (tgt > cur) ? cur + 1'b1 : cur - 1'b1;
    endfunction

endpackage

// File: rtl/flicker_pwm.sv
// 4-bit free-running PWM for the candle LED.
// Provides a registered pwm output and a wrap strobe when the counter is 15.
module flicker_pwm
    import flicker_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    output logic               pwm,
    output logic               wrap
);

    logic [LEVEL_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            pwm <= (cnt < level);
        end
    end

    assign wrap = (cnt == '1);

endmodule

// File: rtl/flicker_sequencer.sv
// Candle-flicker scheduler: advances the LFSR, samples a target, slews level.
// Define FLICKER_FLOOR_EN to clamp sampled targets to at least MIN_LEVEL.
module flicker_sequencer
    import flicker_pkg::*;
#(
    parameter int PRESCALE_W = 12,
    parameter int SHIFTS     = 4,
    parameter int MIN_LEVEL  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [LEVEL_W-1:0] lfsr_value,
    output logic               lfsr_enable,
    output logic               lfsr_reset,
    output logic [LEVEL_W-1:0] level,
    output logic               pwm,
    output logic               busy
);

    localparam logic [3:0] LAST_SHIFT = 4'(SHIFTS - 1);
    localparam logic [LEVEL_W-1:0] FLOOR = LEVEL_W'(MIN_LEVEL);
`ifdef FLICKER_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    state_t                state, state_d;
    logic [PRESCALE_W-1:0] presc;
    logic [3:0]            shift_cnt, shift_cnt_d;
    logic [LEVEL_W-1:0]    target, target_d;
    logic [LEVEL_W-1:0]    level_d;
    logic [LEVEL_W-1:0]    sampled;
    logic                  tick;
    logic                  wrap;

    assign tick = run && (presc == '1);
    assign busy = (state != IDLE);

    assign sampled = (FLOOR_EN && (lfsr_value < FLOOR)) ? FLOOR : lfsr_value;

    always_comb begin
        state_d     = state;
        shift_cnt_d = shift_cnt;
        target_d    = target;
        level_d     = level;
        if (!run) begin
            state_d     = IDLE;
            shift_cnt_d = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tick) state_d = SHIFT;
                end
                SHIFT: begin
                    if (shift_cnt == LAST_SHIFT) begin
                        state_d     = SAMPLE;
                        shift_cnt_d = '0;
                    end else begin
                        shift_cnt_d = shift_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    target_d = sampled;
                    state_d  = RAMP;
                end
                RAMP: begin
                    if (level == target) state_d = IDLE;
                    else if (wrap) level_d = step_toward(level, target);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            presc       <= '0;
            shift_cnt   <= '0;
            target      <= '0;
            level       <= '0;
            lfsr_enable <= 1'b0;
            lfsr_reset  <= 1'b1;
        end else begin
            state       <= state_d;
            presc       <= run ? presc + 1'b1 : '0;
            shift_cnt   <= shift_cnt_d;
            target      <= target_d;
            level       <= level_d;
            lfsr_enable <= (state_d == SHIFT);
            lfsr_reset  <= 1'b0;
        end
    end

    flicker_pwm u_pwm (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .pwm   (pwm),
        .wrap  (wrap)
    );

endmodule

// File: tb/tb_flicker_sequencer.sv
// Scoreboard bench for flicker_sequencer with a stand-in LFSR source.
// Honours FLICKER_FLOOR_EN when computing expected targets.
module tb_flicker_sequencer;

    localparam int PW = 4;
    localparam int SH = 4;
    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [3:0] lfsr_value = 4'h0;
    logic       lfsr_enable;
    logic       lfsr_reset;
    logic [3:0] level;
    logic       pwm;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int episodes = 0;
    int edges = 0;

    logic [3:0] sb[$];
    logic [3:0] force_q[$];

    flicker_sequencer #(
        .PRESCALE_W (PW),
        .SHIFTS     (SH),
        .MIN_LEVEL  (ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .lfsr_value  (lfsr_value),
        .lfsr_enable (lfsr_enable),
        .lfsr_reset  (lfsr_reset),
        .level       (level),
        .pwm         (pwm),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_target(input logic [3:0] v);
`ifdef FLICKER_FLOOR_EN
        return (int'(v) < ML) ? 4'(ML) : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else edges <= edges + 1;
    end

    // LFSR stand-in: a new nibble per advance; the last advance sets the target
    int shift_run = 0;
    always @(negedge clk) begin
        if (!reset) begin
            shift_run = 0;
        end else if (lfsr_enable) begin
            shift_run++;
            if (shift_run == SH) begin
                if (force_q.size() > 0) lfsr_value = force_q.pop_front();
                else lfsr_value = 4'($urandom_range(0, 15));
                sb.push_back(ref_target(lfsr_value));
            end else begin
                lfsr_value = 4'($urandom_range(0, 15));
            end
        end else begin
            if (shift_run > 0 && run) chk("shift_len", shift_run, SH);
            shift_run = 0;
        end
    end

    logic [3:0] prev_level = 4'h0;
    logic       prev_busy = 1'b0;
    logic       moved = 1'b0;
    int         age = 0;
    int         busy_len = 0;
    logic [3:0] exp_t;

    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
            prev_level = level;
            moved = 1'b0;
            age = 0;
            busy_len = 0;
        end else begin
            if (level != prev_level) begin
                chk("move_has_target", int'(sb.size() > 0), 1);
                chk("step_phase", edges % 16, 0);
                if (sb.size() > 0)
                    chk("step", level, (sb[0] > prev_level) ?
                        prev_level + 1 : prev_level - 1);
                age = 0;
                moved = 1'b1;
            end else begin
                age++;
            end
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                if (sb.size() > 0) begin
                    exp_t = sb.pop_front();
                    chk("final_level", level, exp_t);
                    if (moved) chk("busy_fall_lag", age, 1);
                    else chk("busy_len_flat", busy_len, SH + 2);
                    episodes++;
                end else if (run) begin
                    chk("spurious_busy", 1, 0);
                end
                busy_len = 0;
                moved = 1'b0;
            end
            prev_busy = busy;
            prev_level = level;
        end
    end

    task automatic wait_episodes(input int n, input int budget);
        int goal;
        int c;
        goal = episodes + n;
        c = 0;
        while (episodes < goal && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("episode_timeout", int'(episodes >= goal), 1);
    endtask

    task automatic pwm_count(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(pwm);
        end
    endtask

    int en_n;
    int pw_n;
    int hold;
    logic [3:0] lv;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lfsr_reset", lfsr_reset, 1);
        chk("rst_enable", lfsr_enable, 0);
        chk("rst_level", level, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        #1 chk("reseed_hold", lfsr_reset, 1);
        @(posedge clk);
        #1 chk("reseed_drop", lfsr_reset, 0);

        en_n = 0;
        pw_n = 0;
        repeat (30) begin
            @(negedge clk);
            en_n += int'(lfsr_enable);
            pw_n += int'(pwm);
        end
        chk("idle_no_enable", en_n, 0);
        chk("idle_pwm_low", pw_n, 0);
        chk("idle_reseed_low", lfsr_reset, 0);

        force_q.push_back(4'hA);
        @(posedge clk);
        #1 run = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            chk($sformatf("en_c%0d", k), lfsr_enable, int'(k >= 16 && k <= 19));
            chk($sformatf("busy_c%0d", k), busy, int'(k >= 16));
        end
        wait_episodes(1, 600);
        chk("lvl_A", level, ref_target(4'hA));

        force_q.push_back(4'h2);
        wait_episodes(1, 600);
        chk("lvl_2", level, ref_target(4'h2));

        wait_episodes(6, 3600);

        force_q.push_back(4'hF);
        wait_episodes(1, 600);
        chk("lvl_F", level, 15);
        run = 1'b0;
        @(posedge clk);
        #1 chk("stop_busy", busy, 0);
        repeat (2) @(negedge clk);
        pwm_count(16, pw_n);
        chk("pwm_duty_15", pw_n, 15);

        run = 1'b1;
        hold = 0;
        while (!lfsr_enable && hold < 100) begin
            @(negedge clk);
            hold++;
        end
        chk("abort_reach_shift", lfsr_enable, 1);
        @(posedge clk);
        #1 run = 1'b0;
        lv = level;
        @(posedge clk);
        #1;
        chk("abort_enable", lfsr_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_level", level, lv);

        @(posedge clk);
        #1 run = 1'b1;
        force_q.push_back(4'h0);
        hold = 0;
        while (!(busy && level <= 4'd12) && hold < 600) begin
            @(negedge clk);
            hold++;
        end
        chk("ramp_reached", int'(busy && level <= 4'd12), 1);
        #2 reset = 1'b0;
        sb.delete();
        force_q.delete();
        #1;
        chk("async_level", level, 0);
        chk("async_pwm", pwm, 0);
        chk("async_busy", busy, 0);
        chk("async_enable", lfsr_enable, 0);
        chk("async_reseed", lfsr_reset, 1);
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 run = 1'b1;

        wait_episodes(3, 1800);
        run = 1'b0;
        repeat (3) @(negedge clk);
        lv = level;
        pwm_count(16, pw_n);
        chk("pwm_duty_rand", pw_n, int'(lv));

        run = 1'b1;
        force_q.push_back(4'h0);
        wait_episodes(1, 600);
        chk("lvl_0", level, ref_target(4'h0));
        run = 1'b0;
        repeat (3) @(negedge clk);
        lv = level;
        pwm_count(32, pw_n);
        chk("pwm_duty_low", pw_n, 2 * int'(lv));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
